// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of pending doubleword stores drained to backing
// memory in order, with same-cycle youngest-match forwarding for loads.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] cpu_addr,
    input  logic        cpu_wr_en,
    input  logic [63:0] cpu_wdata,
    input  logic        cpu_rd_en,
    output logic [63:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [63:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    input  logic        mem_req_ready,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   addr_q [DEPTH];
    logic [63:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic full;
    logic push;
    logic pop;

    assign full          = (count == CW'(DEPTH));
    assign empty         = (count == '0);
    assign push          = cpu_wr_en && !full;
    assign pop           = !empty && mem_req_ready;
    assign cpu_stall     = cpu_wr_en && full;
    assign mem_req_valid = !empty;
    assign mem_req_addr  = addr_q[rd_ptr];
    assign mem_req_wdata = data_q[rd_ptr];
    assign mem_rd_addr   = cpu_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload is not reset; validity comes solely from count.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[wr_ptr] <= cpu_addr;
            data_q[wr_ptr] <= cpu_wdata;
        end
    end

    // Walk entries oldest to youngest so the last match (youngest) wins,
    // independent of where the pointers sit physically.
    logic [PW-1:0] idx;
    always_comb begin
        cpu_rdata = mem_rd_data;
        idx       = '0;
        if (cpu_rd_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count) && (addr_q[idx][63:3] == cpu_addr[63:3]))
                    cpu_rdata = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH=4): drain order, stall, forwarding,
// wrap-around and reset behaviour.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cpu_addr;
    logic        cpu_wr_en;
    logic [63:0] cpu_wdata;
    logic        cpu_rd_en;
    logic [63:0] cpu_rdata;
    logic        cpu_stall;
    logic [63:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_req_ready;
    logic        empty;

    int total = 0;
    int bad   = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wr_en(cpu_wr_en), .cpu_wdata(cpu_wdata),
        .cpu_rd_en(cpu_rd_en), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        cpu_wr_en = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        cpu_wr_en = 1'b0;
    endtask

    logic [63:0] exp_addr [4];

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_wr_en = 1'b0; cpu_wdata = '0;
        cpu_rd_en = 1'b0; mem_rd_data = '0; mem_req_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_empty", 64'(empty), 1);
        chk("rst_valid", 64'(mem_req_valid), 0);
        chk("rst_count", 64'(dut.count), 0);

        // push/drain with backpressure
        cpu_wr_en = 1'b1; cpu_addr = 64'h10; cpu_wdata = 64'hAA;
        chk("rst_stall", 64'(cpu_stall), 0);
        tick();
        store(64'h18, 64'hBB);
        chk("bd_count", 64'(dut.count), 2);
        chk("bd_valid", 64'(mem_req_valid), 1);
        chk("bd_addr0", mem_req_addr, 64'h10);
        tick();
        chk("bd_hold_addr", mem_req_addr, 64'h10);
        chk("bd_hold_data", mem_req_wdata, 64'hAA);
        chk("bd_empty0", 64'(empty), 0);
        mem_req_ready = 1'b1;
        tick();
        chk("bd_addr1", mem_req_addr, 64'h18);
        chk("bd_data1", mem_req_wdata, 64'hBB);
        tick();
        chk("bd_empty", 64'(empty), 1);
        chk("bd_valid_end", 64'(mem_req_valid), 0);
        mem_req_ready = 1'b0;

        // fill and stall
        store(64'h100, 64'hA1);
        store(64'h108, 64'hA2);
        store(64'h110, 64'hA3);
        store(64'h118, 64'hA4);
        cpu_wr_en = 1'b1; cpu_addr = 64'h40; cpu_wdata = 64'h55;
        #1;
        chk("fs_stall", 64'(cpu_stall), 1);
        tick();
        chk("fs_count_full", 64'(dut.count), 4);
        mem_req_ready = 1'b1;
        tick();
        chk("fs_pop_no_push", 64'(dut.count), 3);
        chk("fs_head", mem_req_addr, 64'h108);
        chk("fs_stall_clear", 64'(cpu_stall), 0);
        mem_req_ready = 1'b0;
        tick();
        cpu_wr_en = 1'b0;
        chk("fs_accept", 64'(dut.count), 4);
        exp_addr[0] = 64'h108; exp_addr[1] = 64'h110;
        exp_addr[2] = 64'h118; exp_addr[3] = 64'h40;
        mem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fs_drain%0d", k), mem_req_addr, exp_addr[k]);
            tick();
        end
        chk("fs_empty", 64'(empty), 1);
        mem_req_ready = 1'b0;

        // forwarding priority
        store(64'h20, 64'h1);
        store(64'h28, 64'h2);
        store(64'h20, 64'h3);
        mem_rd_data = 64'h99;
        cpu_rd_en = 1'b1; cpu_addr = 64'h24; #1;
        chk("fw_youngest", cpu_rdata, 64'h3);
        cpu_addr = 64'h28; #1;
        chk("fw_mid", cpu_rdata, 64'h2);
        cpu_addr = 64'h30; #1;
        chk("fw_miss", cpu_rdata, 64'h99);
        chk("fw_mem_addr", mem_rd_addr, 64'h30);
        cpu_rd_en = 1'b0; cpu_addr = 64'h20; #1;
        chk("fw_rd_off", cpu_rdata, 64'h99);
        cpu_rd_en = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 64'h30; cpu_wdata = 64'h77; #1;
        chk("fw_no_self", cpu_rdata, 64'h99);
        tick();
        cpu_wr_en = 1'b0; #1;
        chk("fw_new", cpu_rdata, 64'h77);
        mem_req_ready = 1'b1;
        tick(); tick(); tick();
        chk("fw_popping", cpu_rdata, 64'h77);
        chk("fw_pop_head", mem_req_addr, 64'h30);
        tick();
        chk("fw_after_pop", cpu_rdata, 64'h99);
        chk("fw_empty", 64'(empty), 1);
        cpu_rd_en = 1'b0; mem_req_ready = 1'b0;

        // wrap-around from a known pointer state
        rst = 1'b1; tick(); rst = 1'b0;
        mem_req_ready = 1'b1; cpu_wr_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cpu_addr = 64'h200 + 64'(8 * k); cpu_wdata = 64'(k);
            tick();
        end
        cpu_wr_en = 1'b0;
        tick();
        mem_req_ready = 1'b0;
        chk("wr_empty", 64'(empty), 1);
        store(64'h300, 64'hF0);
        store(64'h8, 64'h7);
        store(64'h8, 64'h9);
        cpu_rd_en = 1'b1; cpu_addr = 64'h8; mem_rd_data = 64'h5; #1;
        chk("wr_fwd", cpu_rdata, 64'h9);
        cpu_addr = 64'h300; #1;
        chk("wr_fwd_old", cpu_rdata, 64'hF0);
        chk("wr_head", mem_req_addr, 64'h300);
        cpu_rd_en = 1'b0;

        // reset mid-drain
        mem_req_ready = 1'b1; tick();
        mem_req_ready = 1'b0;
        store(64'h10, 64'hEE);
        chk("rm_count", 64'(dut.count), 3);
        rst = 1'b1; mem_req_ready = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 64'h50;
        tick();
        rst = 1'b0; mem_req_ready = 1'b0; cpu_wr_en = 1'b0;
        cpu_rd_en = 1'b1; cpu_addr = 64'h10; mem_rd_data = 64'h1234; #1;
        chk("rm_valid", 64'(mem_req_valid), 0);
        chk("rm_empty", 64'(empty), 1);
        chk("rm_load", cpu_rdata, 64'h1234);
        chk("rm_count0", 64'(dut.count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
